// File: rtl/output_neuron_ctrl.sv
// Output-neuron forward-pass sequencer: streams N_IN x/w pairs through one
// saturating multiply-accumulate, then holds the loss-stage enable for LOSS_LAT cycles.
module output_neuron_ctrl #(
    parameter int N_IN     = 2,
    parameter int ACC_W    = 21,
    parameter int LOSS_LAT = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    output logic [3:0]       addr_o,
    input  logic [9:0]       x_i,
    input  logic [7:0]       w_i,
    output logic             busy_o,
    output logic [ACC_W-1:0] acc_o,
    output logic             acc_vld_o,
    output logic             loss_en_o,
    output logic             done_o,
    output logic             sat_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_LOSS = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [3:0]       LAST_IDX = 4'(N_IN - 1);
    localparam logic [3:0]       LAST_CNT = 4'(LOSS_LAT - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = '1;

    state_t           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             sat_q, sat_d;
    logic             busy_q, busy_d;

    logic [17:0]      prod;
    logic [ACC_W:0]   sum;

    // One extra sum bit catches the overflow that triggers saturation.
    assign prod = x_i * w_i;
    assign sum  = {1'b0, acc_q} + {{(ACC_W + 1 - 18){1'b0}}, prod};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_i) state_d = S_MAC;
            S_MAC:  if (idx_q == LAST_IDX) state_d = S_LOSS;
            S_LOSS: if (cnt_q == LAST_CNT) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort_i) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        idx_d = idx_q;
        cnt_d = cnt_q;
        acc_d = acc_q;
        sat_d = sat_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    acc_d = '0;
                    idx_d = '0;
                    sat_d = 1'b0;
                end
            end
            S_MAC: begin
                if (sum[ACC_W]) begin
                    acc_d = ACC_MAX;
                    sat_d = 1'b1;
                end else begin
                    acc_d = sum[ACC_W-1:0];
                end
                idx_d = (idx_q == LAST_IDX) ? 4'd0 : idx_q + 4'd1;
                cnt_d = '0;
            end
            S_LOSS: cnt_d = (cnt_q == LAST_CNT) ? 4'd0 : cnt_q + 4'd1;
            default: ;
        endcase
        // sat_q deliberately survives an abort so software can see it happened.
        if (abort_i) begin
            acc_d = '0;
            idx_d = '0;
            cnt_d = '0;
            sat_d = sat_q;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            idx_q  <= '0;
            cnt_q  <= '0;
            acc_q  <= '0;
            sat_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            sat_q  <= sat_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        acc_vld_o = (state_q == S_LOSS) && (cnt_q == 4'd0);
        loss_en_o = (state_q == S_LOSS);
        done_o    = (state_q == S_DONE);
    end

    assign addr_o = idx_q;
    assign acc_o  = acc_q;
    assign busy_o = busy_q;
    assign sat_o  = sat_q;

endmodule

// File: tb/tb_output_neuron_ctrl.sv
// Directed bench for output_neuron_ctrl: a 2-input instance for timing, abort,
// start handling and reset, plus a 16-input instance for saturation.
module tb_output_neuron_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start, abort;
    logic [3:0]  addr;
    logic [9:0]  x;
    logic [7:0]  w;
    logic        busy, acc_vld, loss_en, done, sat;
    logic [20:0] acc;

    logic        s_start, s_abort;
    logic [3:0]  s_addr;
    logic [9:0]  s_x;
    logic [7:0]  s_w;
    logic        s_busy, s_acc_vld, s_loss_en, s_done, s_sat;
    logic [20:0] s_acc;

    logic [9:0]  x_mem [16];
    logic [7:0]  w_mem [16];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign x   = x_mem[addr];
    assign w   = w_mem[addr];
    assign s_x = 10'd1023;
    assign s_w = 8'd255;

    output_neuron_ctrl #(.N_IN(2), .ACC_W(21), .LOSS_LAT(2)) u_dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .abort_i(abort),
        .addr_o(addr), .x_i(x), .w_i(w), .busy_o(busy), .acc_o(acc),
        .acc_vld_o(acc_vld), .loss_en_o(loss_en), .done_o(done), .sat_o(sat)
    );

    output_neuron_ctrl #(.N_IN(16), .ACC_W(21), .LOSS_LAT(2)) u_sat (
        .clk_i(clk), .rst_i(rst_n), .start_i(s_start), .abort_i(s_abort),
        .addr_o(s_addr), .x_i(s_x), .w_i(s_w), .busy_o(s_busy), .acc_o(s_acc),
        .acc_vld_o(s_acc_vld), .loss_en_o(s_loss_en), .done_o(s_done), .sat_o(s_sat)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expects IDLE on entry; returns in IDLE one cycle after done.
    task automatic run_basic(input string tag);
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq({tag, " c1 addr"}, 32'(addr), 0);
        check_eq({tag, " c1 busy"}, 32'(busy), 1);
        step();
        check_eq({tag, " c2 addr"}, 32'(addr), 1);
        check_eq({tag, " c2 acc_vld"}, 32'(acc_vld), 0);
        step();
        check_eq({tag, " c3 acc"}, 32'(acc), 704);
        check_eq({tag, " c3 acc_vld"}, 32'(acc_vld), 1);
        check_eq({tag, " c3 loss_en"}, 32'(loss_en), 1);
        step();
        check_eq({tag, " c4 loss_en"}, 32'(loss_en), 1);
        check_eq({tag, " c4 acc_vld"}, 32'(acc_vld), 0);
        step();
        check_eq({tag, " c5 done"}, 32'(done), 1);
        check_eq({tag, " c5 busy"}, 32'(busy), 1);
        check_eq({tag, " c5 loss_en"}, 32'(loss_en), 0);
        step();
        check_eq({tag, " c6 busy"}, 32'(busy), 0);
        check_eq({tag, " c6 done"}, 32'(done), 0);
        check_eq({tag, " c6 acc held"}, 32'(acc), 704);
    endtask

    initial begin
        int pulses;
        int done_cnt;
        int first_done;
        int second_done;
        int acc_bad;

        for (int i = 0; i < 16; i++) begin
            x_mem[i] = '0;
            w_mem[i] = '0;
        end
        x_mem[0] = 10'd3;  w_mem[0] = 8'd128;
        x_mem[1] = 10'd5;  w_mem[1] = 8'd64;

        rst_n = 1'b0;
        start = 1'b0; abort = 1'b0;
        s_start = 1'b0; s_abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst addr", 32'(addr), 0);
        check_eq("rst acc", 32'(acc), 0);
        check_eq("rst busy", 32'(busy), 0);
        check_eq("rst acc_vld", 32'(acc_vld), 0);
        check_eq("rst loss_en", 32'(loss_en), 0);
        check_eq("rst done", 32'(done), 0);
        check_eq("rst sat", 32'(sat), 0);
        rst_n = 1'b1;
        step();

        // Basic pass: 3*128 + 5*64 = 704
        run_basic("basic");

        // Abort in the first MAC cycle
        start = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_eq("abort busy", 32'(busy), 0);
        check_eq("abort acc", 32'(acc), 0);
        check_eq("abort addr", 32'(addr), 0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (acc_vld || done) pulses++;
        end
        check_eq("abort no pulses", 32'(pulses), 0);
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check_eq("abort+start idle busy", 32'(busy), 0);
        step();
        check_eq("abort+start idle loss_en", 32'(loss_en), 0);

        // Start held high: one pass every 6 cycles, result never disturbed
        done_cnt = 0; first_done = 0; second_done = 0; acc_bad = 0;
        start = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) first_done = i;
                if (done_cnt == 2) second_done = i;
            end
            if ((acc_vld || done) && acc != 21'd704) acc_bad++;
        end
        start = 1'b0;
        check_eq("held done count", 32'(done_cnt), 3);
        check_eq("held first done cycle", 32'(first_done), 5);
        check_eq("held pass period", 32'(second_done - first_done), 6);
        check_eq("held acc errors", 32'(acc_bad), 0);
        repeat (6) step();
        check_eq("held drained busy", 32'(busy), 0);

        // Saturation: each product is 260865; 8 adds fit, the 9th overflows
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        check_eq("sat c1 acc", 32'(s_acc), 0);
        repeat (8) step();
        check_eq("sat c9 acc", 32'(s_acc), 2086920);
        check_eq("sat c9 sat", 32'(s_sat), 0);
        step();
        check_eq("sat c10 acc", 32'(s_acc), 2097151);
        check_eq("sat c10 sat", 32'(s_sat), 1);
        repeat (7) step();
        check_eq("sat c17 acc_vld", 32'(s_acc_vld), 1);
        check_eq("sat c17 acc", 32'(s_acc), 2097151);
        repeat (2) step();
        check_eq("sat c19 done", 32'(s_done), 1);
        step();
        check_eq("sat after done busy", 32'(s_busy), 0);
        check_eq("sat after done sat", 32'(s_sat), 1);
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        check_eq("sat restart sat", 32'(s_sat), 0);
        check_eq("sat restart acc", 32'(s_acc), 0);
        repeat (9) step();
        check_eq("sat rerun sat", 32'(s_sat), 1);
        s_abort = 1'b1;
        step();
        s_abort = 1'b0;
        check_eq("sat abort acc", 32'(s_acc), 0);
        check_eq("sat abort busy", 32'(s_busy), 0);
        check_eq("sat abort keeps sat", 32'(s_sat), 1);

        // Asynchronous reset in the first LOSS cycle, between edges
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (2) step();
        check_eq("arst pre loss_en", 32'(loss_en), 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst addr", 32'(addr), 0);
        check_eq("arst acc", 32'(acc), 0);
        check_eq("arst busy", 32'(busy), 0);
        check_eq("arst acc_vld", 32'(acc_vld), 0);
        check_eq("arst loss_en", 32'(loss_en), 0);
        check_eq("arst done", 32'(done), 0);
        check_eq("arst sat", 32'(sat), 0);
        #2 rst_n = 1'b1;
        step();
        run_basic("post-reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
